// File: rtl/ext_mem_pkg.sv
// Shared types and helpers for the external memory responder.
package ext_mem_pkg;

  // Responder control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Result of decoding the latched word address.
  typedef enum logic [1:0] {
    HIT_RAM    = 2'd0,
    HIT_TOHOST = 2'd1,
    MISS       = 2'd2
  } dec_e;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = 4;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] m;
    m = old_w;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/ext_mem_ram.sv
// Single-port word RAM with byte write enables and registered read data.
module ext_mem_ram
  import ext_mem_pkg::*;
#(
  parameter int    MEM_WORDS = 16384,
  parameter string INIT_FILE = "",
  parameter int    AW        = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic [STRB_W-1:0] we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane writes and read-before-write registered output.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_W; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ext_mem_responder.sv
// Target-side responder for the core's external memory bus: RAM, wait states
// and a tohost register for test termination.
module ext_mem_responder
  import ext_mem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
  parameter int          MEM_WORDS   = 16384,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] TOHOST_ADDR = 32'h4000_0000,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_valid,
  input  logic        ext_instruction,
  input  logic [31:0] ext_address,
  input  logic [31:0] ext_write_data,
  input  logic [3:0]  ext_write_strobe,
  output logic        ext_ready,
  output logic [31:0] ext_read_data,
  output logic        access_fault,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [CNT_W-1:0] LAT_M1 = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
  // 33-bit limits so MEM_BASE + size cannot wrap.
  localparam logic [32:0] RAM_LO = {1'b0, MEM_BASE};
  localparam logic [32:0] RAM_HI = RAM_LO + 33'(4 * MEM_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [29:0]       addr_q, addr_d;
  logic [3:0]        strb_q, strb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              instr_q, instr_d;   // debug visibility only
  logic [31:0]       tohost_q, tohost_d;

  dec_e              dec;
  logic [32:0]       byte_addr;
  logic [29:0]       rd_word;
  logic [31:0]       ram_off;
  logic [AW-1:0]     ram_idx;
  logic [3:0]        ram_we;
  logic [31:0]       ram_rdata;
  logic              resp_ok;

  // State and transaction registers; RAM contents are untouched by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      strb_q   <= '0;
      wdata_q  <= '0;
      instr_q  <= 1'b0;
      tohost_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      strb_q   <= strb_d;
      wdata_q  <= wdata_d;
      instr_q  <= instr_d;
      tohost_q <= tohost_d;
    end
  end

  // Next state: accept in IDLE, count wait states, single RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: begin
        if (ext_valid) begin
          addr_d  = ext_address[31:2];
          strb_d  = ext_write_strobe;
          wdata_d = ext_write_data;
          instr_d = ext_instruction;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        // A withdrawn request is abandoned without any commit.
        if (!ext_valid)         state_d = IDLE;
        else if (cnt_q == '0)   state_d = RESP;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode the latched word address.
  always_comb begin
    byte_addr = {1'b0, addr_q, 2'b00};
    if (addr_q == TOHOST_ADDR[31:2])
      dec = HIT_TOHOST;
    else if (byte_addr >= RAM_LO && byte_addr < RAM_HI)
      dec = HIT_RAM;
    else
      dec = MISS;
  end

  // RAM port: in IDLE look at the live address so a zero-latency access has
  // its data registered in time for RESP; otherwise use the latched address.
  always_comb begin
    rd_word = (state_q == IDLE) ? ext_address[31:2] : addr_q;
    ram_off = {rd_word, 2'b00} - MEM_BASE;
    ram_idx = ram_off[AW+1:2];
    ram_we  = '0;
    if (state_q == RESP && dec == HIT_RAM && !reset) ram_we = strb_q;
  end

  // tohost register update on a strobed write during RESP.
  always_comb begin
    tohost_d = tohost_q;
    if (state_q == RESP && dec == HIT_TOHOST && strb_q != '0)
      tohost_d = lane_merge(tohost_q, wdata_q, strb_q);
  end

  // Bus outputs are only driven in RESP; reset suppresses a pending response.
  always_comb begin
    resp_ok       = (state_q == RESP) && !reset;
    ext_ready     = resp_ok;
    access_fault  = resp_ok && (dec == MISS);
    tohost_valid  = resp_ok && (dec == HIT_TOHOST) && (strb_q != '0);
    ext_read_data = '0;
    if (resp_ok) begin
      case (dec)
        HIT_RAM:    ext_read_data = ram_rdata;
        HIT_TOHOST: ext_read_data = tohost_q;
        default:    ext_read_data = '0;
      endcase
    end
  end

  assign tohost_data = tohost_q;

  ext_mem_ram #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_FILE (INIT_FILE),
    .AW        (AW)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_idx),
    .we    (ram_we),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule
